// File: rtl/load_store_unit.sv
// Sub-word load/store adapter in front of a word-only memory: RMW for SB/SH, sign/zero extension for loads.
// Build option: define LSU_MISALIGN_TRAP_EN to fault misaligned H/W accesses instead of force-aligning them.
module load_store_unit #(
  parameter int ADDR_BITS = 12
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_is_store,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_fault,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_wr_en,
  output logic        mem_rd_en,
  input  logic [31:0] mem_rdata
);

  localparam logic [31:0] ADDR_MASK = (ADDR_BITS >= 32) ? 32'hFFFF_FFFF
                                    : ((32'd1 << ADDR_BITS) - 32'd1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RD    = 3'd1,
    WR    = 3'd2,
    MERGE = 3'd3,
    RESP  = 3'd4
  } state_t;

  state_t      state, state_next;
  logic        accept;
  logic        illegal, fault_dec;
  logic [1:0]  off_dec;

  logic        store_q, fault_q;
  logic [2:0]  funct3_q;
  logic [1:0]  off_q;
  logic [29:0] word_addr_q;
  logic [31:0] wdata_q, word_q;
  logic [31:0] aligned_addr;

  function automatic logic [31:0] extend_load(input logic [31:0] word,
                                              input logic [1:0]  off,
                                              input logic [2:0]  f3);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    b = word[{off, 3'b000} +: 8];
    h = word[{off[1], 4'b0000} +: 16];
    case (f3)
      3'b000:  return 32'(b);
      3'b001:  return 32'(h);
      3'b100:  return {24'd0, b};
      3'b101:  return {16'd0, h};
      default: return word;
    endcase
  endfunction

  function automatic logic [31:0] merge_store(input logic [31:0] word,
                                              input logic [15:0] data,
                                              input logic [1:0]  off,
                                              input logic        half);
    logic [31:0] m;
    m = word;
    if (half) m[{off[1], 4'b0000} +: 16] = data;
    else      m[{off, 3'b000} +: 8]      = data[7:0];
    return m;
  endfunction

  assign accept       = (state == IDLE) && req_valid && !reset;
  assign aligned_addr = {word_addr_q, 2'b00} & ADDR_MASK;

  // Request decode, evaluated on the raw request fields at the accept edge
  always_comb begin
    illegal   = (req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11) ||
                (req_is_store && req_funct3[2]);
    off_dec   = req_addr[1:0];
`ifdef LSU_MISALIGN_TRAP_EN
    fault_dec = illegal ||
                (req_funct3[1:0] == 2'b01 && req_addr[0]) ||
                (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00);
`else
    fault_dec = illegal;
    if (req_funct3[1:0] == 2'b01)      off_dec[0] = 1'b0;
    else if (req_funct3[1:0] == 2'b10) off_dec    = 2'b00;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      store_q     <= req_is_store;
      funct3_q    <= req_funct3;
      word_addr_q <= req_addr[31:2];
      off_q       <= off_dec;
      wdata_q     <= req_wdata;
      fault_q     <= fault_dec;
    end
    if (state == RD) word_q <= mem_rdata;
  end

  // Write enables are gated by reset so a WR/MERGE cycle under reset never commits
  always_comb begin
    state_next = state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    resp_rdata = 32'd0;
    resp_fault = 1'b0;
    mem_addr   = 32'd0;
    mem_wdata  = 32'd0;
    mem_wr_en  = 1'b0;
    mem_rd_en  = 1'b0;
    case (state)
      IDLE: begin
        req_ready = !reset;
        if (accept) begin
          if (fault_dec)                           state_next = RESP;
          else if (!req_is_store)                  state_next = RD;
          else if (req_funct3[1:0] == 2'b10)       state_next = WR;
          else                                     state_next = RD;
        end
      end
      RD: begin
        mem_rd_en  = !reset;
        mem_addr   = aligned_addr;
        state_next = store_q ? MERGE : RESP;
      end
      WR: begin
        mem_wr_en  = !reset;
        mem_addr   = aligned_addr;
        mem_wdata  = wdata_q;
        state_next = RESP;
      end
      MERGE: begin
        mem_wr_en  = !reset;
        mem_addr   = aligned_addr;
        mem_wdata  = merge_store(word_q, wdata_q[15:0], off_q, funct3_q[0]);
        state_next = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        resp_fault = fault_q;
        if (!fault_q && !store_q) resp_rdata = extend_load(word_q, off_q, funct3_q);
        if (resp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: word-level memory model, per-cycle expectation queue, random traffic.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_is_store = 1'b0;
  logic [2:0]  req_funct3 = 3'd0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [31:0] resp_rdata;
  logic        resp_fault;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_wr_en;
  logic        mem_rd_en;
  logic [31:0] mem_rdata;

  int checks = 0;
  int failures = 0;
  logic mon_en = 1'b0;
  logic load_mem = 1'b0;

  logic [31:0] env_mem [0:1023];
  logic [31:0] ref_mem [0:1023];

  typedef struct packed {
    logic        rr, rv, rd, wr, flt;
    logic [31:0] ad, wd, rdat;
  } exp_t;
  exp_t expq [$];

  load_store_unit #(.ADDR_BITS(12)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_is_store(req_is_store), .req_funct3(req_funct3),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_fault(resp_fault),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wr_en(mem_wr_en), .mem_rd_en(mem_rd_en),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Word-only memory the DUT talks to: combinational read, write at the rising edge
  assign mem_rdata = env_mem[mem_addr[11:2]];
  always @(posedge clk) begin
    if (load_mem) begin
      for (int i = 0; i < 1024; i++) env_mem[i] <= ref_mem[i];
    end else if (mem_wr_en) begin
      env_mem[mem_addr[11:2]] <= mem_wdata;
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", name, got, exp);
    end
  endtask

  // Reference: what a request must do, from the ISA width rules on whole words
  function automatic void model(input logic st, input logic [2:0] f3, input logic [31:0] a,
                                input logic [31:0] wd, output logic flt, output logic [31:0] rdat,
                                output logic [31:0] merged, output int kind);
    int          sz, o, idx;
    bit          ill, mis;
    logic [31:0] old, v, msk, lane;
    sz  = int'(f3[1:0]);
    o   = int'(a[1:0]);
    ill = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111) || (st && f3[2]);
    mis = (sz == 1 && a[0]) || (sz == 2 && a[1:0] != 2'b00);
    flt = ill;
`ifdef LSU_MISALIGN_TRAP_EN
    if (mis) flt = 1'b1;
`else
    if (mis && sz == 1) o = o & 2;
    if (sz == 2) o = 0;
`endif
    idx    = int'((a & 32'h0000_0FFF) >> 2);
    old    = ref_mem[idx];
    rdat   = 32'd0;
    merged = 32'd0;
    if (flt) begin
      kind = 0;
    end else if (!st) begin
      kind = 1;
      v = old >> (8 * o);
      case (f3)
        3'b000:  rdat = ((v & 32'hFF) >= 32'd128)     ? (v & 32'hFF) - 32'd256     : (v & 32'hFF);
        3'b001:  rdat = ((v & 32'hFFFF) >= 32'd32768) ? (v & 32'hFFFF) - 32'd65536 : (v & 32'hFFFF);
        3'b100:  rdat = v & 32'hFF;
        3'b101:  rdat = v & 32'hFFFF;
        default: rdat = old;
      endcase
    end else if (sz == 2) begin
      kind = 2;
      ref_mem[idx] = wd;
    end else begin
      kind = 3;
      msk    = (sz == 0) ? 32'hFF : 32'hFFFF;
      lane   = msk << (8 * o);
      merged = (old & ~lane) | ((wd & msk) << (8 * o));
      ref_mem[idx] = merged;
    end
  endfunction

  task automatic do_req(input logic st, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input int h,
                        output logic [31:0] got, output logic gotf);
    logic        flt;
    logic [31:0] rdat, merged, ad;
    int          kind, lat, n;
    exp_t        e;
    @(negedge clk);
    req_is_store = st; req_funct3 = f3; req_addr = a; req_wdata = wd; req_valid = 1'b1;
    n = 0;
    while (!req_ready) begin
      n++;
      if (n > 20) begin
        failures++; checks++;
        $display("FAIL accept_timeout got=req_ready_low expected=req_ready_high");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "accept timeout");
      end
      @(negedge clk);
    end
    @(posedge clk);
    model(st, f3, a, wd, flt, rdat, merged, kind);
    ad  = a & 32'h0000_0FFC;
    lat = (kind == 0) ? 1 : (kind == 3) ? 3 : 2;
    if (kind == 1 || kind == 3) begin
      e = '0; e.rd = 1'b1; e.ad = ad; expq.push_back(e);
    end
    if (kind == 2 || kind == 3) begin
      e = '0; e.wr = 1'b1; e.ad = ad; e.wd = (kind == 2) ? wd : merged; expq.push_back(e);
    end
    repeat (h + 1) begin
      e = '0; e.rv = 1'b1; e.rdat = rdat; e.flt = flt; expq.push_back(e);
    end
    #1 req_valid = 1'b0;
    repeat (lat - 1 + h) @(posedge clk);
    @(negedge clk);
    got = resp_rdata; gotf = resp_fault; resp_ready = 1'b1;
    @(posedge clk);
    #1 resp_ready = 1'b0;
  endtask

  // Per-cycle comparison against the expectation queue; an empty queue means idle
  always @(negedge clk) begin
    exp_t e;
    bit   ok;
    if (mon_en && !reset) begin
      if (expq.size() > 0) e = expq.pop_front();
      else begin e = '0; e.rr = 1'b1; end
      ok = (req_ready === e.rr) && (resp_valid === e.rv) &&
           (mem_rd_en === e.rd) && (mem_wr_en === e.wr);
      if (e.rd || e.wr) ok = ok && (mem_addr === e.ad);
      if (e.wr)         ok = ok && (mem_wdata === e.wd);
      if (e.rv)         ok = ok && (resp_rdata === e.rdat) && (resp_fault === e.flt);
      checks++;
      if (!ok) begin
        failures++;
        $display("FAIL cycle t=%0t got rr=%b rv=%b rd=%b wr=%b ad=%h wd=%h rdata=%h flt=%b expected rr=%b rv=%b rd=%b wr=%b ad=%h wd=%h rdata=%h flt=%b",
                 $time, req_ready, resp_valid, mem_rd_en, mem_wr_en, mem_addr, mem_wdata,
                 resp_rdata, resp_fault, e.rr, e.rv, e.rd, e.wr, e.ad, e.wd, e.rdat, e.flt);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout expected=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  task automatic chk_all_zero(input string name);
    chk({name, "_ctl"}, {27'd0, req_ready, resp_valid, resp_fault, mem_wr_en, mem_rd_en}, 32'd0);
    chk({name, "_rdata"}, resp_rdata, 32'd0);
    chk({name, "_addr"}, mem_addr, 32'd0);
    chk({name, "_wdata"}, mem_wdata, 32'd0);
  endtask

  initial begin
    logic [31:0] g;
    logic        f;
    logic [2:0]  tbl [10];
    int          mism;
    tbl = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd0, 3'd1, 3'd2, 3'd3, 3'd7};
    for (int i = 0; i < 1024; i++) ref_mem[i] = $urandom;
    ref_mem[32'h40] = 32'h8899AABB;
    load_mem = 1'b1;
    @(posedge clk);
    #1 load_mem = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_all_zero("reset");
    reset = 1'b0;
    #1 mon_en = 1'b1;

    do_req(1'b0, 3'b000, 32'h101, 32'd0, 0, g, f); chk("lb_101", g, 32'hFFFFFFAA);
    do_req(1'b0, 3'b100, 32'h103, 32'd0, 0, g, f); chk("lbu_103", g, 32'h00000088);
    do_req(1'b0, 3'b101, 32'h102, 32'd0, 0, g, f); chk("lhu_102", g, 32'h00008899);
    do_req(1'b0, 3'b010, 32'h102, 32'd0, 0, g, f);
`ifdef LSU_MISALIGN_TRAP_EN
    chk("lw_mis_fault", {31'd0, f}, 32'd1); chk("lw_mis_rdata", g, 32'd0);
`else
    chk("lw_mis_fault", {31'd0, f}, 32'd0); chk("lw_mis_rdata", g, 32'h8899AABB);
`endif
    do_req(1'b1, 3'b001, 32'h102, 32'hDEAD1234, 0, g, f);
    chk("sh_mem", env_mem[32'h40], 32'h1234AABB);
    do_req(1'b0, 3'b010, 32'h100, 32'd0, 0, g, f); chk("lw_after_sh", g, 32'h1234AABB);
    do_req(1'b1, 3'b010, 32'h104, 32'hCAFEF00D, 0, g, f); chk("sw_rdata", g, 32'd0);
    chk("sw_mem", env_mem[32'h41], 32'hCAFEF00D);
    do_req(1'b0, 3'b010, 32'h100, 32'd0, 5, g, f); chk("lw_hold", g, 32'h1234AABB);
    do_req(1'b0, 3'b011, 32'h100, 32'd0, 0, g, f); chk("f3_011_fault", {31'd0, f}, 32'd1);
    chk("f3_011_rdata", g, 32'd0);
    do_req(1'b1, 3'b100, 32'h100, 32'h77, 1, g, f); chk("store_bu_fault", {31'd0, f}, 32'd1);

    // Reset landing on the MERGE cycle of an SB must not write
    @(negedge clk);
    mon_en = 1'b0;
    req_is_store = 1'b1; req_funct3 = 3'b000; req_addr = 32'h100; req_wdata = 32'h55; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    chk("rmw_rd_en", {31'd0, mem_rd_en}, 32'd1);
    @(negedge clk);
    chk("merge_wr_en", {31'd0, mem_wr_en}, 32'd1);
    reset = 1'b1;
    #1 chk("merge_suppressed", {31'd0, mem_wr_en}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk_all_zero("reset_mid");
    reset = 1'b0;
    #1 mon_en = 1'b1;
    chk("mem_unchanged", env_mem[32'h40], 32'h1234AABB);

    for (int n = 0; n < 250; n++) begin
      logic        st;
      logic [2:0]  f3;
      logic [31:0] a;
      st = ($urandom_range(0, 99) < 40);
      f3 = tbl[$urandom_range(0, 9)];
      a  = ($urandom & 32'hFFFF_F000) | (32'h100 + 32'($urandom_range(0, 255)));
      do_req(st, f3, a, $urandom, $urandom_range(0, 3), g, f);
    end

    mism = 0;
    for (int i = 0; i < 1024; i++) if (env_mem[i] !== ref_mem[i]) mism++;
    chk("mem_final_mismatches", 32'(mism), 32'd0);

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
